// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared requester encoding and default widths for sram_arbiter
package sram_arbiter_pkg;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_INST = 0;
  localparam int GNT_DATA = 1;

endpackage

// File: rtl/sram_arbiter_arb_pick.sv
// rtl/sram_arbiter_arb_pick.sv - combinational two-way pick, inst wins a conflict when inst_pri is set
module arb_pick
  import sram_arbiter_pkg::*;
(
  input  logic       inst_req,
  input  logic       data_req,
  input  logic       inst_pri,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (inst_req && (!data_req || inst_pri)) begin
      grant[GNT_INST] = 1'b1;
    end else if (data_req) begin
      grant[GNT_DATA] = 1'b1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - inst/data arbiter onto one single-port SRAM; SRAM_ARB_RR_EN selects round-robin
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  logic       inst_req_v;
  logic       data_req_v;
  logic       inst_pri;
  logic [1:0] grant;
  logic       resp_valid;
  src_e       resp_src;

  // Requests are masked during reset so no grant or SRAM access leaks out.
  assign inst_req_v = inst_req & resetn;
  assign data_req_v = data_req & resetn;

  arb_pick u_arb_pick (
    .inst_req (inst_req_v),
    .data_req (data_req_v),
    .inst_pri (inst_pri),
    .grant    (grant)
  );

`ifdef SRAM_ARB_RR_EN
  src_e rr_last;

  assign inst_pri = (rr_last == SRC_DATA);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_last <= SRC_INST;
    end else if (|grant) begin
      rr_last <= grant[GNT_DATA] ? SRC_DATA : SRC_INST;
    end
  end
`else
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign inst_pri = (starve_cnt == CNT_W'(STARVE_MAX));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (!inst_req || grant[GNT_INST]) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`endif

  assign inst_addr_ok = grant[GNT_INST];
  assign data_addr_ok = grant[GNT_DATA];

  always_comb begin
    sram_en    = |grant;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (grant[GNT_DATA]) begin
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
      if (data_wr) begin
        sram_we = data_wstrb;
      end
    end else if (grant[GNT_INST]) begin
      sram_addr = inst_addr;
    end
  end

  // One access in flight at most; its response lands exactly one cycle later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_valid <= 1'b0;
      resp_src   <= SRC_INST;
    end else begin
      resp_valid <= |grant;
      resp_src   <= grant[GNT_DATA] ? SRC_DATA : SRC_INST;
    end
  end

  assign inst_data_ok = resp_valid && (resp_src == SRC_INST);
  assign data_data_ok = resp_valid && (resp_src == SRC_DATA);
  assign inst_rdata   = sram_rdata;
  assign data_rdata   = sram_rdata;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester arbiter that shares one synchronous single-port SRAM between the CPU's instruction-fetch port and data port. It sits between the pipelined core and the unified memory, replacing separate inst/data SRAMs. It grants at most one request per cycle, tracks the single outstanding access, and returns read data or write completion to the correct requester one cycle later.

## Interface
- ADDR_W, 32, address width of both ports and the SRAM
- DATA_W, 32, data width; byte strobe width is DATA_W/8
- STARVE_MAX, 4, consecutive inst losses before inst is forced (fixed-priority mode only)

- clk  in  1  clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_req  in  1  fetch request
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid this cycle
- inst_rdata  out  DATA_W  fetch data
- data_req  in  1  data request
- data_wr  in  1  1 = write, 0 = read
- data_wstrb  in  DATA_W/8  byte enables for writes
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  write data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  read data valid / write done this cycle
- data_rdata  out  DATA_W  read data
- sram_en  out  1  SRAM access this cycle
- sram_we  out  DATA_W/8  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid cycle after address

## Operation
- Handshake: requester holds req, addr, wr, wstrb, wdata stable until addr_ok; transfer happens in the cycle req && addr_ok. Exactly one data_ok per accepted request, in order.
- Each cycle the arbiter picks a winner among asserted reqs; winner gets addr_ok (combinational from req and state), SRAM driven from winner's fields, sram_en=1, sram_we=wstrb if data write else 0. No winner: sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0.
- Response tracking: registered resp_valid and resp_src (INST/DATA). Set on a grant, cleared otherwise. Next cycle: resp_valid drives the matching *_data_ok; rdata outputs both carry sram_rdata (qualified by data_ok). Writes also return data_ok.
- Grant allowed in same cycle as a pending data_ok (full throughput, one access per cycle).
- Fixed priority (default): data beats inst. starve_cnt increments each cycle inst_req loses, clears on inst grant or inst_req low; when starve_cnt == STARVE_MAX inst wins that cycle. Counter saturates, width clog2(STARVE_MAX+1).
- Single requester always wins immediately.

## Timing
- Accept-to-data latency exactly 1 cycle; throughput 1 access/cycle.
- Reset (resetn low, asynchronous): resp_valid=0, resp_src=INST, starve_cnt=0, rr pointer=INST; all addr_ok/data_ok/sram_en/sram_we low while resetn low. Reset mid-access drops the pending response; no data_ok after release.
- Simultaneous reqs: exactly one addr_ok high; loser holds and retries next cycle.
- First grant possible in the first cycle after resetn rises.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin; 1-bit last-grant pointer, on conflict the port not granted last wins; STARVE_MAX and starve_cnt absent.
- Undefined: fixed data priority with starvation counter as above.

## Structure
- Shared package/header: requester encoding (SRC_INST=0, SRC_DATA=1), default widths.
- One sub-module arb_pick: inputs inst_req, data_req, state (starve flag or rr pointer), output one-hot grant; purely combinational.

## Test plan
- Inst only, addr 0x1c000000, sram_rdata 0x02800421 next cycle -> inst_addr_ok cycle 0, inst_data_ok cycle 1 with 0x02800421, data_data_ok never.
- Data write addr 0x100, wstrb 0xF, wdata 0xDEADBEEF -> sram_we=0xF same cycle, data_data_ok next cycle; readback returns 0xDEADBEEF.
- Both req continuously, fixed priority, STARVE_MAX=4 -> data granted 4 cycles, inst on 5th, pattern repeats; no cycle with two addr_ok.
- Same with SRAM_ARB_RR_EN -> grants alternate DATA, INST, DATA... starting per pointer after reset (DATA first).
- Back-to-back inst reads to 0x0,0x4,0x8 -> addr_ok three consecutive cycles, data_ok three consecutive cycles, in order.
- resetn low in cycle after grant -> no data_ok, all outputs 0; after release, first request served normally.
